spi_display_arbiter: RTL and testbench

Two-master arbiter and frame assembler in front of the shared SPI seven-segment display path.
- Two SPI requesters (A and B) share one sclk; each has its own ss and mosi.
- The block grants the display to one requester per frame and assembles that requester's FRAME_BITS-bit command MSB-first.
- It presents the command to the decoder/blink logic as a one-cycle cmd_valid strobe.
- Losing and malformed frames are dropped and flagged.

---
 rtl/spi_display_arbiter.sv | 167 ++++++++++++++++
 tb/tb_spi_display_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/spi_display_arbiter.sv
// Two-requester SPI arbiter and MSB-first frame assembler feeding the seven-segment command path.
// Build option: define SPI_ARB_CMD_FILTER_EN to forward only display (2'b10) and blink (2'b01) frames.

module spi_arb_lane (
    input  logic sclk,
    input  logic rst_n,
    input  logic ss,
    output logic sel,
    output logic fall
);
    logic ss_q;

    always_ff @(posedge sclk) begin
        if (!rst_n) ss_q <= 1'b1;
        else        ss_q <= ss;
    end

    assign sel  = ~ss;
    assign fall = ss_q & ~ss;
endmodule

module spi_display_arbiter #(
    parameter int FRAME_BITS = 6,
    parameter int CNT_W      = 4
) (
    input  logic                  sclk,
    input  logic                  rst_n,
    input  logic                  ss_a,
    input  logic                  mosi_a,
    input  logic                  ss_b,
    input  logic                  mosi_b,
    output logic                  cmd_valid,
    output logic [FRAME_BITS-1:0] cmd_data,
    output logic                  cmd_src,
    output logic                  grant_a,
    output logic                  grant_b,
    output logic                  deny_pulse,
    output logic                  short_err,
    output logic                  ovr_err
);
    localparam int               NUM_REQ  = 2;
    localparam int               SH_W     = FRAME_BITS - 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {IDLE, RX, HOLD} state_t;

    state_t              state;
    logic                owner;
    logic                last_src;
    logic                ovr_seen;
    logic [CNT_W-1:0]    cnt;
    logic [SH_W-1:0]     shreg;

    logic [NUM_REQ-1:0]  ss_vec, mosi_vec, req_sel, req_fall;
    logic                idle_win, owner_sel, other_fall, owner_mosi, frame_ok;
    logic [FRAME_BITS-1:0] frame_next;

    assign ss_vec   = {ss_b, ss_a};
    assign mosi_vec = {mosi_b, mosi_a};

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_lane
            spi_arb_lane u_lane (
                .sclk  (sclk),
                .rst_n (rst_n),
                .ss    (ss_vec[g]),
                .sel   (req_sel[g]),
                .fall  (req_fall[g])
            );
        end
    endgenerate

    // On a tie the requester that did not complete the last frame wins.
    assign idle_win   = (&req_sel) ? ~last_src : req_sel[1];
    assign owner_sel  = req_sel[owner];
    assign other_fall = req_fall[~owner];
    assign owner_mosi = mosi_vec[owner];
    assign frame_next = {shreg, owner_mosi};

`ifdef SPI_ARB_CMD_FILTER_EN
    assign frame_ok = (frame_next[FRAME_BITS-1 -: 2] == 2'b10) ||
                      (frame_next[FRAME_BITS-1 -: 2] == 2'b01);
`else
    assign frame_ok = 1'b1;
`endif

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_src   <= 1'b1;
            ovr_seen   <= 1'b0;
            cnt        <= '0;
            shreg      <= '0;
            cmd_valid  <= 1'b0;
            cmd_data   <= '0;
            cmd_src    <= 1'b0;
            grant_a    <= 1'b0;
            grant_b    <= 1'b0;
            deny_pulse <= 1'b0;
            short_err  <= 1'b0;
            ovr_err    <= 1'b0;
        end else begin
            cmd_valid  <= 1'b0;
            deny_pulse <= 1'b0;
            short_err  <= 1'b0;
            ovr_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_sel) begin
                        owner      <= idle_win;
                        state      <= RX;
                        cnt        <= CNT_W'(1);
                        shreg      <= SH_W'(mosi_vec[idle_win]);
                        grant_a    <= ~idle_win;
                        grant_b    <= idle_win;
                        deny_pulse <= &req_sel;
                    end
                end
                RX: begin
                    if (other_fall) deny_pulse <= 1'b1;
                    if (owner_sel) begin
                        if (cnt == LAST_CNT) begin
                            last_src <= owner;
                            state    <= HOLD;
                            if (frame_ok) begin
                                cmd_valid <= 1'b1;
                                cmd_data  <= frame_next;
                                cmd_src   <= owner;
                                ovr_seen  <= 1'b0;
                            end else begin
                                // Rejected command: the reject counts as the frame's overrun pulse.
                                ovr_err   <= 1'b1;
                                ovr_seen  <= 1'b1;
                            end
                        end else begin
                            shreg <= SH_W'(frame_next);
                            cnt   <= cnt + CNT_W'(1);
                        end
                    end else begin
                        short_err <= 1'b1;
                        state     <= IDLE;
                        cnt       <= '0;
                        grant_a   <= 1'b0;
                        grant_b   <= 1'b0;
                    end
                end
                HOLD: begin
                    if (other_fall) deny_pulse <= 1'b1;
                    if (owner_sel) begin
                        if (!ovr_seen) begin
                            ovr_err  <= 1'b1;
                            ovr_seen <= 1'b1;
                        end
                    end else begin
                        state   <= IDLE;
                        cnt     <= '0;
                        grant_a <= 1'b0;
                        grant_b <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_display_arbiter.sv
// Directed bench for spi_display_arbiter: ties, round-robin, short/overrun frames, deny, filter, reset.

module tb_spi_display_arbiter;
    logic       sclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ss_a = 1'b1, mosi_a = 1'b0, ss_b = 1'b1, mosi_b = 1'b0;
    logic       cmd_valid, cmd_src, grant_a, grant_b, deny_pulse, short_err, ovr_err;
    logic [5:0] cmd_data;
    logic [5:0] f;
    logic [7:0] g;
    int         n_vec = 0;
    int         n_miss = 0;

    always #5 sclk = ~sclk;

    spi_display_arbiter #(.FRAME_BITS(6), .CNT_W(4)) dut (
        .sclk       (sclk),
        .rst_n      (rst_n),
        .ss_a       (ss_a),
        .mosi_a     (mosi_a),
        .ss_b       (ss_b),
        .mosi_b     (mosi_b),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .cmd_src    (cmd_src),
        .grant_a    (grant_a),
        .grant_b    (grant_b),
        .deny_pulse (deny_pulse),
        .short_err  (short_err),
        .ovr_err    (ovr_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply inputs, clock one edge, settle for sampling.
    task automatic step(input logic sa, input logic ma, input logic sb, input logic mb);
        ss_a = sa; mosi_a = ma; ss_b = sb; mosi_b = mb;
        @(posedge sclk);
        #1;
    endtask

    initial begin
        // Reset held with both selects low
        rst_n = 1'b0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("rst_flags", {cmd_valid, grant_a, grant_b, deny_pulse, short_err, ovr_err}, 6'b0);
        chk("rst_data", cmd_data, 6'b0);
        chk("rst_src", cmd_src, 1'b0);

        // First tie after reset goes to A; A sends 100101
        rst_n = 1'b1;
        f = 6'b100101;
        step(0, f[5], 0, 0);
        chk("tie1_grant", {grant_a, grant_b}, 2'b10);
        chk("tie1_deny", deny_pulse, 1'b1);
        for (int i = 4; i >= 0; i--) begin
            step(0, f[i], 0, 0);
            if (i == 4) chk("tie1_deny_once", deny_pulse, 1'b0);
            if (i > 0)  chk("a_no_early_valid", cmd_valid, 1'b0);
        end
        chk("a_valid", cmd_valid, 1'b1);
        chk("a_data", cmd_data, 6'b100101);
        chk("a_src", cmd_src, 1'b0);
        step(1, 0, 1, 0);
        chk("a_valid_one_cycle", cmd_valid, 1'b0);
        chk("a_grant_drop", {grant_a, grant_b}, 2'b00);
        chk("a_no_ovr", ovr_err, 1'b0);

        // Second tie: B wins round-robin, sends 011010
        f = 6'b011010;
        step(0, 0, 0, f[5]);
        chk("tie2_grant", {grant_a, grant_b}, 2'b01);
        chk("tie2_deny", deny_pulse, 1'b1);
        for (int i = 4; i >= 0; i--) step(0, 0, 0, f[i]);
        chk("b_valid", cmd_valid, 1'b1);
        chk("b_data", cmd_data, 6'b011010);
        chk("b_src", cmd_src, 1'b1);
        step(1, 0, 1, 0);
        chk("b_grant_drop", grant_b, 1'b0);
        step(1, 0, 1, 0);

        // Third tie: A again; overrun frame 01001111, B re-selects mid-frame
        g = 8'b01001111;
        step(0, g[7], 0, 0);
        chk("tie3_grant", {grant_a, grant_b}, 2'b10);
        chk("tie3_deny", deny_pulse, 1'b1);
        step(0, g[6], 1, 0);
        chk("tie3_deny_clear", deny_pulse, 1'b0);
        step(0, g[5], 0, 0);
        chk("nonowner_fall_deny", deny_pulse, 1'b1);
        step(0, g[4], 0, 0);
        chk("nonowner_deny_once", deny_pulse, 1'b0);
        step(0, g[3], 0, 0);
        step(0, g[2], 0, 0);
        chk("ovr_valid", cmd_valid, 1'b1);
        chk("ovr_data", cmd_data, 6'b010011);
        chk("ovr_src", cmd_src, 1'b0);
        step(0, g[1], 0, 0);
        chk("ovr_bit7", ovr_err, 1'b1);
        chk("ovr_bit7_novalid", cmd_valid, 1'b0);
        step(0, g[0], 0, 0);
        chk("ovr_bit8", ovr_err, 1'b0);
        step(1, 0, 0, 0);
        chk("release_no_grant", {grant_a, grant_b}, 2'b00);

        // B alone: 3-bit short frame
        step(1, 0, 0, 1);
        chk("short_grant", {grant_a, grant_b, deny_pulse}, 3'b010);
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        step(1, 0, 1, 0);
        chk("short_err", short_err, 1'b1);
        chk("short_novalid", cmd_valid, 1'b0);
        chk("short_data_kept", cmd_data, 6'b010011);
        chk("short_grant_drop", grant_b, 1'b0);
        step(1, 0, 1, 0);
        chk("short_err_one_cycle", short_err, 1'b0);

        // Command code 11 frame from A
        f = 6'b110000;
        for (int i = 5; i >= 0; i--) step(0, f[i], 1, 0);
`ifdef SPI_ARB_CMD_FILTER_EN
        chk("filt_novalid", cmd_valid, 1'b0);
        chk("filt_ovr", ovr_err, 1'b1);
        chk("filt_data_kept", cmd_data, 6'b010011);
`else
        chk("code11_valid", cmd_valid, 1'b1);
        chk("code11_data", cmd_data, 6'b110000);
        chk("code11_no_ovr", ovr_err, 1'b0);
`endif
        step(1, 0, 1, 0);
        chk("code11_grant_drop", grant_a, 1'b0);

        // Reset mid-frame aborts silently
        step(0, 1, 1, 0);
        step(0, 0, 1, 0);
        rst_n = 1'b0;
        step(0, 0, 1, 0);
        chk("midrst_flags", {cmd_valid, grant_a, grant_b, deny_pulse, short_err, ovr_err}, 6'b0);
        chk("midrst_data", cmd_data, 6'b0);
        rst_n = 1'b1;
        step(1, 0, 1, 0);
        chk("midrst_quiet", {cmd_valid, grant_a, grant_b, deny_pulse, short_err, ovr_err}, 6'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
